// File: rtl/vme_pkg.sv
// rtl/vme_pkg.sv - shared constants and state encoding for the VME bus requester
// Contents:
//   ACTIVE / INACTIVE       levels of the active-low VME lines
//   DEFAULT_SYNC_STAGES     default depth of the input synchronisers
//   ST_* / req_state_e      requester state encoding
package vme_pkg;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  localparam int DEFAULT_SYNC_STAGES = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQUEST  = 3'd1;
  localparam logic [2:0] ST_WAIT_DTB = 3'd2;
  localparam logic [2:0] ST_OWNED    = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    REQUEST  = ST_REQUEST,
    WAIT_DTB = ST_WAIT_DTB,
    OWNED    = ST_OWNED,
    RELEASE  = ST_RELEASE
  } req_state_e;

endpackage

// File: rtl/vme_sync.sv
// rtl/vme_sync.sv - N-flop synchroniser for asynchronous VME inputs
// Ports:
//   clock   system clock
//   reset   synchronous active-high reset, loads RESET_VAL into every stage
//   d       asynchronous input
//   q       synchronised output, STAGES clocks behind d
module vme_sync #(
  parameter int               STAGES    = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/vme_bus_requester.sv
// rtl/vme_bus_requester.sv - card-side VME bus requester on one BR/BG level
// Optional feature: define VME_REQ_FAIR_EN for a fair requester (waits for
// BR[BR_LEVEL] to be released by others before requesting).
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   local_req             local master wants the bus (level)
//   local_cycle_active    local master mid-transfer, blocks release
//   local_grant           bus owned, local master may drive the DTB
//   vme_bgin / vme_bgout  BG daisy chain in / out, active-low
//   vme_br_in             sensed BR[BR_LEVEL] (fair build only)
//   vme_br_drive          1 = pull BR[BR_LEVEL] low
//   vme_bbsy_in           sensed BBSY, active-low
//   vme_bbsy_drive        1 = pull BBSY low
//   vme_bclr              bus clear, active-low
//   vme_address_strobe    sensed AS, active-low
module vme_bus_requester
  import vme_pkg::*;
#(
  parameter int BR_LEVEL         = 3,
  parameter int RELEASE_ON_CLEAR = 1,
  parameter int BBSY_MIN_CYCLES  = 8,
  parameter int SYNC_STAGES      = DEFAULT_SYNC_STAGES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       local_req,
  input  logic       local_cycle_active,
  output logic       local_grant,
  input  logic [3:0] vme_bgin,
  output logic [3:0] vme_bgout,
  input  logic       vme_br_in,
  output logic       vme_br_drive,
  input  logic       vme_bbsy_in,
  output logic       vme_bbsy_drive,
  input  logic       vme_bclr,
  input  logic       vme_address_strobe
);

  localparam logic [1:0] LVL   = BR_LEVEL[1:0];
  localparam int         CNT_W = (BBSY_MIN_CYCLES > 1) ? $clog2(BBSY_MIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(BBSY_MIN_CYCLES - 1);

  logic [3:0] bgin_s;
  logic       br_s, bbsy_s, bclr_s, as_s;

  vme_sync #(.STAGES(SYNC_STAGES), .WIDTH(4), .RESET_VAL(4'hF)) u_sync_bgin (
    .clock(clock), .reset(reset), .d(vme_bgin), .q(bgin_s));
  vme_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RESET_VAL(1'b1)) u_sync_br (
    .clock(clock), .reset(reset), .d(vme_br_in), .q(br_s));
  vme_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RESET_VAL(1'b1)) u_sync_bbsy (
    .clock(clock), .reset(reset), .d(vme_bbsy_in), .q(bbsy_s));
  vme_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RESET_VAL(1'b1)) u_sync_bclr (
    .clock(clock), .reset(reset), .d(vme_bclr), .q(bclr_s));
  vme_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RESET_VAL(1'b1)) u_sync_as (
    .clock(clock), .reset(reset), .d(vme_address_strobe), .q(as_s));

  // Sensed BBSY is not needed: ownership is decided by the daisy chain and AS.
  logic unused_bbsy;
  assign unused_bbsy = bbsy_s;

  logic br_clear;
`ifdef VME_REQ_FAIR_EN
  assign br_clear = (br_s == INACTIVE);
`else
  logic unused_br;
  assign br_clear  = 1'b1;
  assign unused_br = br_s;
`endif

  req_state_e       state, state_next;
  logic             pass_latch, pass_next, bg_prev;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       bgout_next;
  logic             bg_active, bg_rise, clear_req, release_ok;

  assign bg_active = (bgin_s[LVL] == ACTIVE);
  assign bg_rise   = bg_active && (bg_prev == INACTIVE);

  // A grant is passed only if it starts while we are not requesting; once
  // passing, it keeps passing until BG goes away, whatever local_req does.
  always_comb begin
    pass_next = pass_latch;
    if (!bg_active)
      pass_next = 1'b0;
    else if (bg_rise && state != REQUEST)
      pass_next = 1'b1;
  end

  assign clear_req  = (RELEASE_ON_CLEAR != 0) && (bclr_s == ACTIVE);
  assign release_ok = (hold_cnt == '0) && !local_cycle_active &&
                      (!local_req || clear_req);

  always_comb begin
    state_next = state;
    unique case (state)
      // pass_next (not pass_latch) so a grant arriving this very cycle is
      // passed down the chain instead of racing our own request.
      IDLE:     if (local_req && !pass_next && br_clear) state_next = REQUEST;
      // Absorb wins over withdrawal so the grant is never lost to the chain.
      REQUEST:  if (bg_active)               state_next = WAIT_DTB;
                else if (!local_req)         state_next = IDLE;
      WAIT_DTB: if (as_s == INACTIVE)        state_next = OWNED;
      OWNED:    if (release_ok)              state_next = RELEASE;
      // Hold off until the old grant is gone so it cannot be reused.
      RELEASE:  if (!bg_active)              state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  always_comb begin
    bgout_next      = bgin_s;
    bgout_next[LVL] = pass_next ? bgin_s[LVL] : INACTIVE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      pass_latch     <= 1'b0;
      bg_prev        <= INACTIVE;
      hold_cnt       <= '0;
      local_grant    <= 1'b0;
      vme_br_drive   <= 1'b0;
      vme_bbsy_drive <= 1'b0;
      vme_bgout      <= 4'hF;
    end else begin
      state      <= state_next;
      pass_latch <= pass_next;
      bg_prev    <= bgin_s[LVL];
      // Hold time is measured from BBSY assertion, so it also runs in WAIT_DTB.
      if (state == REQUEST && state_next == WAIT_DTB)
        hold_cnt <= HOLD_LOAD;
      else if ((state == WAIT_DTB || state == OWNED) && hold_cnt != '0)
        hold_cnt <= hold_cnt - CNT_W'(1);
      // Drives are registered decodes of the next state: glitch-free enables.
      local_grant    <= (state_next == OWNED);
      vme_br_drive   <= (state_next == REQUEST);
      vme_bbsy_drive <= (state_next == WAIT_DTB) || (state_next == OWNED);
      vme_bgout      <= bgout_next;
    end
  end

endmodule

// File: tb/tb_vme_bus_requester.sv
// tb/tb_vme_bus_requester.sv - self-checking bench for vme_bus_requester
`timescale 1ns/1ps
module tb_vme_bus_requester;

  localparam int BBSY_MIN = 8;
  localparam int VLAT     = 3;  // synchroniser depth plus output register
`ifdef VME_REQ_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       local_req, local_cycle_active, local_grant;
  logic [3:0] vme_bgin, vme_bgout;
  logic       vme_br_in, vme_br_drive, vme_bbsy_in, vme_bbsy_drive;
  logic       vme_bclr, vme_address_strobe;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ready = 0;
  logic [2:0] hist [8];

  always #5 clock = ~clock;

  vme_bus_requester dut (
    .clock(clock), .reset(reset),
    .local_req(local_req), .local_cycle_active(local_cycle_active),
    .local_grant(local_grant),
    .vme_bgin(vme_bgin), .vme_bgout(vme_bgout),
    .vme_br_in(vme_br_in), .vme_br_drive(vme_br_drive),
    .vme_bbsy_in(vme_bbsy_in), .vme_bbsy_drive(vme_bbsy_drive),
    .vme_bclr(vme_bclr), .vme_address_strobe(vme_address_strobe)
  );

  typedef struct {
    logic [3:0] bgin;
    logic [3:0] bgout;
  } vec_t;
  vec_t vecs [9];

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic [6:0] exp_o(input logic g, input logic br,
                                       input logic bb, input logic [3:0] bo);
    return {g, br, bb, bo};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {local_grant, vme_br_drive, vme_bbsy_drive, vme_bgout};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d {grant,br,bbsy,bgout} actual=%b required=%b",
               name, cyc, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One bus tenure on level 3, expected waveform derived from event times:
  //   g     cycles from BR assertion until the arbiter drives BG3
  //   as_x  cycles AS stays active after BG3 is driven (0 = AS idle)
  //   rd    local_req drop, relative to BBSY assertion (-1 = with absorption)
  //   ld    local_cycle_active fall, relative to BBSY assertion
  //   bd    BCLR assertion relative to BBSY assertion, when use_bc
  //   rr    cycles after release before the arbiter withdraws BG3
  //   gap   cycles after BG3 withdrawal before the next request starts
  task automatic run_txn(input int g, input int as_x, input int rd, input int ld,
                         input bit use_bc, input int bd, input int rr, input int gap);
    int s, e_br, t_g, e_bb, t_as, e_gr, t_rd, t_ld, t_bc, reqterm, e_fall;
    int t_rel, s_next, c;
    bit drive_bc;
    logic [2:0] lo;
    s     = cyc;
    e_br  = imax(s + 1, ready);
    t_g   = e_br + g;
    e_bb  = t_g + VLAT;
    t_as  = t_g + as_x;
    e_gr  = (as_x > 0) ? imax(e_bb + 1, t_as + VLAT) : e_bb + 1;
    t_rd  = e_bb + rd;
    t_ld  = e_bb + ld;
    t_bc  = e_bb + bd;
    reqterm = t_rd + 1;
    if (use_bc && t_bc + VLAT < reqterm) reqterm = t_bc + VLAT;
    e_fall = imax(imax(e_bb + BBSY_MIN, e_gr + 1), imax(t_ld + 1, reqterm));
    drive_bc = use_bc && (t_bc < e_fall);
    if (t_rd > e_fall) t_rd = e_fall;
    t_rel  = e_fall + rr;
    s_next = t_rel + gap;
    ready  = t_rel + VLAT + 1;
    local_req = 1'b1;
    while (cyc < s_next) begin
      if (cyc == t_g) begin
        vme_bgin[3] = 1'b0;
        local_cycle_active = 1'b1;
        if (as_x > 0) vme_address_strobe = 1'b0;
      end
      if (as_x > 0 && cyc == t_as) vme_address_strobe = 1'b1;
      if (cyc == t_rd) local_req = 1'b0;
      if (cyc == t_ld) local_cycle_active = 1'b0;
      if (drive_bc && cyc == t_bc) vme_bclr = 1'b0;
      if (cyc == t_rel) begin
        vme_bgin[3] = 1'b1;
        vme_bclr = 1'b1;
      end
      lo = 3'($urandom_range(0, 7));
      vme_bgin[2:0] = lo;
      hist[3'(cyc)] = lo;
      tick();
      c = cyc;
      check("txn", exp_o(c >= e_gr && c < e_fall, c >= e_br && c < e_bb,
                         c >= e_bb && c < e_fall, {1'b1, hist[3'(c - VLAT)]}));
    end
  endtask

  initial begin
    logic [3:0] prev;
    vecs[0] = '{4'b1110, 4'b1110};
    vecs[1] = '{4'b1100, 4'b1100};
    vecs[2] = '{4'b1111, 4'b1111};
    vecs[3] = '{4'b1010, 4'b1010};
    vecs[4] = '{4'b0101, 4'b0101};
    vecs[5] = '{4'b0000, 4'b0000};
    vecs[6] = '{4'b1111, 4'b1111};
    vecs[7] = '{4'b0110, 4'b0110};
    vecs[8] = '{4'b1111, 4'b1111};

    reset = 1'b1;
    local_req = 1'b0;
    local_cycle_active = 1'b0;
    vme_bgin = 4'hF;
    vme_br_in = 1'b1;
    vme_bbsy_in = 1'b1;
    vme_bclr = 1'b1;
    vme_address_strobe = 1'b1;
    for (int i = 0; i < 8; i++) hist[i] = 3'b111;

    tick();
    check("reset_state", exp_o(0, 0, 0, 4'hF));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("idle_after_reset", exp_o(0, 0, 0, 4'hF));

    // Daisy-chain pass-through while not requesting, latency VLAT.
    prev = 4'hF;
    for (int i = 0; i < 9; i++) begin
      vme_bgin = vecs[i].bgin;
      tick();
      tick();
      check("vec_hold", exp_o(0, 0, 0, prev));
      tick();
      check("vec_pass", exp_o(0, 0, 0, vecs[i].bgout));
      tick();
      prev = vecs[i].bgout;
    end

    // Grant being passed is not absorbed by a request raised mid-grant.
    vme_bgin = 4'b0111;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) local_req = 1'b1;
      tick();
      check("pass_grant", exp_o(0, 0, 0, (k >= 3) ? 4'b0111 : 4'b1111));
    end
    vme_bgin = 4'hF;
    tick();
    check("pass_defer", exp_o(0, 0, 0, 4'b0111));
    tick();
    check("pass_defer", exp_o(0, 0, 0, 4'b0111));
    tick();
    check("req_after_pass", exp_o(0, 1, 0, 4'hF));
    local_req = 1'b0;
    tick();
    check("req_withdraw", exp_o(0, 0, 0, 4'hF));

    // BR sensed active: demand requester ignores it, fair requester waits.
    vme_br_in = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    local_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("br_in_low", exp_o(0, !FAIR, 0, 4'hF));
    end
    vme_br_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("br_in_high", exp_o(0, FAIR ? (k >= 3) : 1'b1, 0, 4'hF));
    end
    local_req = 1'b0;
    tick();
    check("br_drop", exp_o(0, 0, 0, 4'hF));

    // Acquire, then reset while owned.
    local_req = 1'b1;
    tick();
    check("acq_br", exp_o(0, 1, 0, 4'hF));
    vme_bgin = 4'b0111;
    tick();
    tick();
    check("acq_wait", exp_o(0, 1, 0, 4'hF));
    tick();
    check("acq_absorb", exp_o(0, 0, 1, 4'hF));
    tick();
    check("acq_owned", exp_o(1, 0, 1, 4'hF));
    reset = 1'b1;
    tick();
    check("reset_owned", exp_o(0, 0, 0, 4'hF));
    local_req = 1'b0;
    vme_bgin = 4'hF;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("idle_after_reset2", exp_o(0, 0, 0, 4'hF));

    // Directed tenures, then randomized ones.
    ready = 0;
    run_txn(3, 0, 2, 0, 1'b0, 0, 1, 2);     // plain acquire, minimum hold
    run_txn(0, 6, 0, 0, 1'b0, 0, 0, 1);     // AS busy after absorption
    run_txn(1, 0, 13, 13, 1'b1, 0, 2, 3);   // BCLR while mid-cycle
    run_txn(2, 0, -1, 0, 1'b0, 0, 0, 1);    // request dropped as grant arrives
    run_txn(0, 2, 20, 0, 1'b1, 9, 3, 4);    // BCLR release with request held
    for (int n = 0; n < 30; n++) begin
      int g, asx, rd, ld, bd, rr, gap;
      bit ubc;
      g   = int'($urandom_range(0, 4));
      asx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      rd  = int'($urandom_range(0, 13)) - 1;
      ld  = int'($urandom_range(0, 14));
      ubc = ($urandom_range(0, 1) == 1);
      bd  = int'($urandom_range(0, 12));
      rr  = int'($urandom_range(0, 3));
      gap = int'($urandom_range(1, 4));
      run_txn(g, asx, rd, ld, ubc, bd, rr, gap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vme_bus_requester.md
Name: vme_bus_requester

Overview:
- Card-side VME bus requester; consumer of the system controller arbiter's bus-grant daisy chain.
- Asserts BR on one configured level and propagates or absorbs the BG daisy chain on that level.
- Acquires bus ownership with BBSY and hands a grant to the local master.
- Releases the bus on local completion, or on BCLR when release-on-clear is enabled.
- VME signals are active-low (0 = ACTIVE, 1 = INACTIVE). Open-drain lines are driven through enable outputs.

Parameters:
- BR_LEVEL, 3, request/grant level used (0-3).
- RELEASE_ON_CLEAR, 1, 1 = give up the bus when BCLR is asserted, even with a local request pending.
- BBSY_MIN_CYCLES, 8, minimum clocks BBSY is held asserted; must be >=1.
- SYNC_STAGES, 2, flops on each asynchronous VME input; must be >=2.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- local_req  input  1  local master wants the bus; level, held until granted.
- local_cycle_active  input  1  local master is mid-transfer; blocks release while high.
- local_grant  output  1  bus owned, local master may drive the DTB.
- vme_bgin  input  4  BG daisy-chain inputs, active-low.
- vme_bgout  output  4  BG daisy-chain outputs, active-low.
- vme_br_in  input  1  sensed level of BR[BR_LEVEL] (used only with the optional feature).
- vme_br_drive  output  1  1 = pull BR[BR_LEVEL] low.
- vme_bbsy_in  input  1  sensed BBSY, active-low.
- vme_bbsy_drive  output  1  1 = pull BBSY low.
- vme_bclr  input  1  bus clear from the arbiter, active-low.
- vme_address_strobe  input  1  sensed AS, active-low.

Behaviour:
- All VME inputs pass through SYNC_STAGES flops. Every condition below refers to the synchronised value.
- Reset values: state=IDLE, local_grant=0, vme_br_drive=0, vme_bbsy_drive=0, vme_bgout=4'b1111, hold counter=0, pass latch=0.
- Daisy chain, levels other than BR_LEVEL: vme_bgout[i] = synced vme_bgin[i], registered, 1-cycle latency.
- Daisy chain, BR_LEVEL, pass latch:
  - Latch sets when bgin goes ACTIVE while state is not REQUEST.
  - Latch clears when bgin goes INACTIVE.
  - While the latch is set, bgout follows bgin. Otherwise bgout is INACTIVE.
  - A grant already being passed is never absorbed, even if local_req rises mid-grant.
- States:
  - IDLE: local_req=1 and pass latch=0 → REQUEST, vme_br_drive=1.
  - REQUEST: bgin[BR_LEVEL] ACTIVE → WAIT_DTB and the grant is absorbed (bgout stays INACTIVE). local_req dropping here → IDLE, br_drive=0.
  - WAIT_DTB: on entry bbsy_drive=1 and br_drive=0; hold counter is loaded with BBSY_MIN_CYCLES-1. Stay until AS is INACTIVE. Then → OWNED, local_grant=1 the next cycle.
  - OWNED: the counter decrements to 0. Release condition = counter==0 AND local_cycle_active=0 AND (local_req=0 OR (RELEASE_ON_CLEAR=1 AND bclr ACTIVE)). When met → RELEASE; local_grant=0 and bbsy_drive=0 in the same cycle.
  - RELEASE: wait until bgin[BR_LEVEL] is INACTIVE, so a stale grant is never reused. Then → IDLE. Re-request is possible the cycle after.
- Simultaneous events:
  - BCLR plus counter expiry plus local_cycle_active=1: hold until the cycle ends.
  - local_req deasserting in the same cycle that the grant arrives: still absorb the grant, take the bus, then release per the normal rule (preserves chain integrity).
  - bclr in OWNED with RELEASE_ON_CLEAR=0: ignored.
- Reset mid-operation: all drives drop to their reset values the next clock, regardless of state.

Optional Feature:
- VME_REQ_FAIR_EN defined: IDLE→REQUEST additionally requires vme_br_in INACTIVE (fair requester; waits for the level to clear before joining).
- Undefined: vme_br_in is ignored (demand requester).

Decomposition:
- Package vme_pkg: ACTIVE/INACTIVE constants, requester state enum (IDLE, REQUEST, WAIT_DTB, OWNED, RELEASE), default SYNC_STAGES.
- Sub-module vme_sync: parameterised N-flop synchroniser, instantiated per input.

Test Plan:
- local_req=1, bgin[3] asserted 3 cycles later:
  - br_drive=1 until absorption.
  - bgout[3] stays 1.
  - bbsy_drive=1.
  - local_grant=1 once AS is INACTIVE.
- Not requesting, bgin[3]=0 for 10 cycles, local_req raised mid-grant:
  - bgout[3] follows bgin (after SYNC_STAGES+1 latency).
  - Request is deferred until bgin returns to 1.
- Owned, local_req dropped at cycle 2 with BBSY_MIN_CYCLES=8: bbsy_drive is held until 8 cycles after assertion, then 0.
- RELEASE_ON_CLEAR=1, owned, bclr=0, local_cycle_active=1 for 5 cycles: release occurs 1 cycle after local_cycle_active falls.
- AS held ACTIVE 6 cycles after the grant is absorbed: local_grant stays 0 until AS=1.
- VME_REQ_FAIR_EN, vme_br_in=0, local_req=1: br_drive stays 0 until vme_br_in=1. Reset asserted in OWNED clears all outputs the next cycle.
